cp0_except_commit: RTL and testbench
====================================

// Module: cp0_except_commit
// PURPOSE
//  CP0 register file plus exception/ERET commit at the MEM/WB boundary. Consumes the prioritised
//  excepttype code and commit PC, updates Status/Cause/EPC, emits a one-cycle pipeline flush and
//  redirect PC. Drives status_o/cause_o back to the interrupt prioritiser; owns Count/Compare timer.
// PARAMETERS
//  EXC_VECTOR  32'hBFC0_0380  general exception handler address
//  COUNT_DIV   2              Count increments once every COUNT_DIV cycles (1 or 2)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  excepttype_i    in   32  code: 0 none, 1-8 IP0-IP7, 9 SYSCALL, 10 RI, 11 OV, 12 BREAK, 13 ERET
//  pc_i            in   32  PC of committing instruction
//  in_delayslot_i  in   1   committing instruction sits in branch delay slot
//  int_i           in   6   external hardware interrupt lines (level)
//  cp0_we_i        in   1   mtc0 write enable
//  cp0_waddr_i     in   5   mtc0 register number
//  cp0_wdata_i     in   32  mtc0 data
//  cp0_raddr_i     in   5   mfc0 register number
//  cp0_rdata_o     out  32  mfc0 data (combinational, current register value, no bypass)
//  status_o        out  32  Status(12)
//  cause_o         out  32  Cause(13)
//  epc_o           out  32  EPC(14)
//  flush_o         out  1   one-cycle pipeline flush
//  redirect_pc_o   out  32  fetch target, valid while flush_o=1
// BEHAVIOUR
//  Reset: Status, Cause, EPC, Count, Compare, timer_pending=0; flush_o=0; redirect_pc_o=0; FSM=IDLE.
//  Registers: Count(9), Compare(11), Status(12), Cause(13), EPC(14); other addresses read 0, writes dropped.
//  Status writable bits: IM[15:8], EXL[1], IE[0]; rest read 0.
//  Cause: BD[31], IP[15:8], ExcCode[6:2]; only IP[9:8] writable by mtc0.
//   IP[14:10] <= int_i[4:0] each cycle; IP[15] <= int_i[5] | timer_pending.
//  Timer: Count += 1 every COUNT_DIV cycles (wraps 32'hFFFF_FFFF->0); timer_pending set on cycle
//   Count==Compare and Compare!=0; cleared by any mtc0 to Compare. mtc0 to Count overrides increment.
//  FSM IDLE/FLUSH:
//   IDLE, excepttype_i in 1..12: next cycle flush_o=1, redirect_pc_o=EXC_VECTOR; Status.EXL<=1;
//    ExcCode<=0 (1-8), 8 (9), 10 (10), 12 (11), 9 (12); if EXL was 0: EPC<=in_delayslot_i?pc_i-4:pc_i,
//    BD<=in_delayslot_i; if EXL was 1 EPC/BD unchanged. ->FLUSH.
//   IDLE, excepttype_i==13: flush_o=1, redirect_pc_o=EPC (pre-update value), EXL<=0. ->FLUSH.
//   IDLE, excepttype_i==0 or >13: no action; stay IDLE.
//   FLUSH: flush_o=1 for this single cycle; excepttype_i and cp0_we_i ignored (flushed junk). ->IDLE.
//  Latency: excepttype_i sampled at edge N, flush_o/redirect_pc_o high during cycle N+1 only.
//  Simultaneous mtc0 + nonzero excepttype_i: mtc0 suppressed (instruction does not commit).
//  mtc0 to Cause/Status same cycle as hardware IP update: hardware IP[15:10] wins, mtc0 for rest.
//  Reset mid-FLUSH: flush_o drops next cycle, FSM IDLE, all registers to reset values.
// STRUCTURE
//  cp0_pkg: register numbers, excepttype codes 0-13, ExcCode constants, Status/Cause bit positions,
//   writable masks, FSM state typedef.
//  Sub-module cp0_timer: Count/Compare/divider/timer_pending; top holds Status/Cause/EPC/FSM.
// TESTING
//  Reset then idle 10 cycles -> all outputs 0, Count==5 (COUNT_DIV=2).
//  excepttype_i=9, pc_i=32'h8000_0100, in_delayslot_i=0 -> next cycle flush_o=1,
//   redirect=32'hBFC0_0380, EPC=32'h8000_0100, ExcCode=8, EXL=1; flush_o=0 cycle after.
//  excepttype_i=11, pc_i=32'h8000_0204, delayslot=1 -> EPC=32'h8000_0200, BD=1, ExcCode=12;
//   then excepttype_i=13 -> flush_o=1, redirect=32'h8000_0200, EXL=0.
//  mtc0 Compare=8, Count=0 -> Cause[15]=1 after Count hits 8; mtc0 Compare=20 -> Cause[15]=0.
//  EXL=1, excepttype_i=10 with new pc -> EPC/BD unchanged, ExcCode=10, flush asserted.
//  excepttype_i=9 same cycle as mtc0 Status=32'hFF01 -> Status unchanged except EXL=1; second
//   excepttype_i=9 in FLUSH cycle ignored (single flush pulse).

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, excepttype codes, ExcCode values,
// Status/Cause bit positions and writable masks, and the commit FSM state type.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [31:0] EXC_NONE    = 32'd0;
  localparam logic [31:0] EXC_INT0    = 32'd1;
  localparam logic [31:0] EXC_INT7    = 32'd8;
  localparam logic [31:0] EXC_SYSCALL = 32'd9;
  localparam logic [31:0] EXC_RI      = 32'd10;
  localparam logic [31:0] EXC_OV      = 32'd11;
  localparam logic [31:0] EXC_BREAK   = 32'd12;
  localparam logic [31:0] EXC_ERET    = 32'd13;

  localparam logic [4:0] EXCCODE_INT = 5'd0;
  localparam logic [4:0] EXCCODE_SYS = 5'd8;
  localparam logic [4:0] EXCCODE_BP  = 5'd9;
  localparam logic [4:0] EXCCODE_RI  = 5'd10;
  localparam logic [4:0] EXCCODE_OV  = 5'd12;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_HWIP_LSB = 10;
  localparam int CAUSE_TI      = 15;
  localparam int CAUSE_BD      = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_SWMASK = 32'h0000_0300;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } cp0_state_e;

  function automatic logic [4:0] exc_code(input logic [31:0] et);
    case (et)
      EXC_SYSCALL: exc_code = EXCCODE_SYS;
      EXC_RI:      exc_code = EXCCODE_RI;
      EXC_OV:      exc_code = EXCCODE_OV;
      EXC_BREAK:   exc_code = EXCCODE_BP;
      default:     exc_code = EXCCODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV cycles, and a
// sticky pending flag is raised on Count==Compare until Compare is rewritten.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_pending_o
);

  logic        div_q, div_d;
  logic        tick;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  always_comb begin
    div_d = (COUNT_DIV == 1) ? 1'b0 : ~div_q;
    tick  = (COUNT_DIV == 1) ? 1'b1 : div_q;

    count_d = count_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end

    compare_d = compare_we_i ? wdata_i : compare_q;

    // Compare==0 is treated as "timer disarmed".
    pending_d = pending_q;
    if (compare_we_i) begin
      pending_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o         = count_q;
  assign compare_o       = compare_q;
  assign timer_pending_o = pending_q;

endmodule

// File: rtl/cp0_except_commit.sv
// CP0 Status/Cause/EPC plus exception/ERET commit FSM: a committing trap or
// ERET produces a single-cycle flush with the fetch redirect target.
module cp0_except_commit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [5:0]  int_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [4:0]  cp0_raddr_i,
  output logic [31:0] cp0_rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o
);

  cp0_state_e  state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] count, compare;
  logic        timer_pending;
  logic        idle, is_trap, is_eret, mtc0_ok;

  // Anything arriving during the flush cycle is squashed junk; an mtc0 only
  // commits when its instruction raises no exception.
  assign idle    = (state_q == S_IDLE);
  assign is_trap = idle && (excepttype_i >= EXC_INT0) && (excepttype_i <= EXC_BREAK);
  assign is_eret = idle && (excepttype_i == EXC_ERET);
  assign mtc0_ok = idle && cp0_we_i && (excepttype_i == EXC_NONE);

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .count_we_i     (mtc0_ok && (cp0_waddr_i == CP0_COUNT)),
    .compare_we_i   (mtc0_ok && (cp0_waddr_i == CP0_COMPARE)),
    .wdata_i        (cp0_wdata_i),
    .count_o        (count),
    .compare_o      (compare),
    .timer_pending_o(timer_pending)
  );

  always_comb begin
    state_d    = S_IDLE;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    redirect_d = redirect_q;

    if (mtc0_ok) begin
      case (cp0_waddr_i)
        CP0_STATUS: status_d = cp0_wdata_i & STATUS_WMASK;
        CP0_CAUSE:  cause_d  = (cause_q & ~CAUSE_SWMASK) | (cp0_wdata_i & CAUSE_SWMASK);
        CP0_EPC:    epc_d    = cp0_wdata_i;
        default:    ;
      endcase
    end

    if (is_trap) begin
      state_d                            = S_FLUSH;
      redirect_d                         = EXC_VECTOR;
      status_d[STATUS_EXL]               = 1'b1;
      cause_d[CAUSE_EXC_LSB +: 5]        = exc_code(excepttype_i);
      // Nested exceptions keep the original return point.
      if (!status_q[STATUS_EXL]) begin
        epc_d             = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        cause_d[CAUSE_BD] = in_delayslot_i;
      end
    end else if (is_eret) begin
      state_d              = S_FLUSH;
      redirect_d           = epc_q;
      status_d[STATUS_EXL] = 1'b0;
    end

    // Hardware interrupt lines overwrite IP[15:10] every cycle, after any mtc0.
    cause_d[CAUSE_HWIP_LSB +: 5] = int_i[4:0];
    cause_d[CAUSE_TI]            = int_i[5] | timer_pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      status_q   <= 32'd0;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      redirect_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
    end
  end

  always_comb begin
    case (cp0_raddr_i)
      CP0_COUNT:   cp0_rdata_o = count;
      CP0_COMPARE: cp0_rdata_o = compare;
      CP0_STATUS:  cp0_rdata_o = status_q;
      CP0_CAUSE:   cp0_rdata_o = cause_q;
      CP0_EPC:     cp0_rdata_o = epc_q;
      default:     cp0_rdata_o = 32'd0;
    endcase
  end

  assign status_o      = status_q;
  assign cause_o       = cause_q;
  assign epc_o         = epc_q;
  assign flush_o       = (state_q == S_FLUSH);
  assign redirect_pc_o = redirect_q;

endmodule

// File: tb/tb_cp0_except_commit.sv
// Scoreboard bench for cp0_except_commit: directed scenarios then random
// traffic, checked each cycle against a behavioural model of the CP0 rules.
module tb_cp0_except_commit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          DIV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] excepttype, pc, wdata;
  logic        ds, we;
  logic [5:0]  intv;
  logic [4:0]  waddr, raddr;
  logic [31:0] rdata, status, cause, epc, redirect;
  logic        flush;

  cp0_except_commit #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .excepttype_i(excepttype), .pc_i(pc),
    .in_delayslot_i(ds), .int_i(intv), .cp0_we_i(we), .cp0_waddr_i(waddr),
    .cp0_wdata_i(wdata), .cp0_raddr_i(raddr), .cp0_rdata_o(rdata),
    .status_o(status), .cause_o(cause), .epc_o(epc), .flush_o(flush),
    .redirect_pc_o(redirect)
  );

  typedef struct packed {
    logic        flush;
    logic [31:0] redirect, status, cause, epc, count, compare;
  } exp_t;
  exp_t q[$];

  // Architectural state as the specification describes it
  logic        m_flush, m_pend;
  logic [31:0] m_redirect, m_status, m_cause, m_epc, m_count, m_compare;
  int unsigned m_cyc;

  int checks = 0;
  int fails  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [4:0] code_of(input logic [31:0] et);
    if (et == 9)  return 5'd8;
    if (et == 10) return 5'd10;
    if (et == 11) return 5'd12;
    if (et == 12) return 5'd9;
    return 5'd0;
  endfunction

  task automatic model_step();
    logic        commits, trap, eret, n_pend;
    logic [31:0] n_status, n_cause, n_epc, n_count, n_compare;
    if (rst) begin
      m_flush = 0; m_pend = 0; m_redirect = 0; m_status = 0; m_cause = 0;
      m_epc = 0; m_count = 0; m_compare = 0; m_cyc = 0;
      return;
    end
    commits = we && !m_flush && (excepttype == 0);
    trap    = !m_flush && (excepttype >= 1) && (excepttype <= 12);
    eret    = !m_flush && (excepttype == 13);
    m_cyc++;
    n_count   = (commits && waddr == 9) ? wdata
              : ((m_cyc % DIV) == 0) ? m_count + 1 : m_count;
    n_compare = (commits && waddr == 11) ? wdata : m_compare;
    if (commits && waddr == 11)                      n_pend = 0;
    else if (m_compare != 0 && m_count == m_compare) n_pend = 1;
    else                                             n_pend = m_pend;
    n_status = (commits && waddr == 12) ? (wdata & 32'h0000_FF03) : m_status;
    n_cause  = m_cause;
    if (commits && waddr == 13) n_cause[9:8] = wdata[9:8];
    n_epc = (commits && waddr == 14) ? wdata : m_epc;
    if (trap) begin
      n_status[1]   = 1;
      n_cause[6:2]  = code_of(excepttype);
      if (!m_status[1]) begin
        n_epc       = ds ? pc - 4 : pc;
        n_cause[31] = ds;
      end
    end
    if (eret) n_status[1] = 0;
    n_cause[14:10] = intv[4:0];
    n_cause[15]    = intv[5] | m_pend;
    m_redirect = trap ? VEC : eret ? m_epc : m_redirect;
    m_flush    = trap || eret;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_count = n_count; m_compare = n_compare; m_pend = n_pend;
  endtask

  // Drive one cycle of inputs, record the expected post-edge state, wait for the edge.
  task automatic cyc(input logic r, input logic [31:0] et, input logic [31:0] p,
                     input logic d, input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [5:0] iv, input logic [4:0] ra);
    exp_t e;
    rst = r; excepttype = et; pc = p; ds = d; we = w; waddr = wa;
    wdata = wd; intv = iv; raddr = ra;
    model_step();
    e.flush = m_flush; e.redirect = m_redirect; e.status = m_status;
    e.cause = m_cause; e.epc = m_epc; e.count = m_count; e.compare = m_compare;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, ra);
  endtask

  task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
    cyc(0, 0, 0, 0, 1, wa, wd, 0, 13);
  endtask

  // Monitor: every cycle, compare DUT against the oldest expectation
  initial begin
    exp_t        e;
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("flush", {31'd0, flush}, {31'd0, e.flush});
        chk("redirect", redirect, e.redirect);
        chk("status", status, e.status);
        chk("cause", cause, e.cause);
        chk("epc", epc, e.epc);
        case (raddr)
          5'd9:    exp_rd = e.count;
          5'd11:   exp_rd = e.compare;
          5'd12:   exp_rd = e.status;
          5'd13:   exp_rd = e.cause;
          5'd14:   exp_rd = e.epc;
          default: exp_rd = 32'd0;
        endcase
        chk("rdata", rdata, exp_rd);
      end
    end
  end

  initial begin
    logic [4:0] addrs [6];
    logic [31:0] et, wd;
    logic [4:0]  wa;
    logic [5:0]  iv;
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 9);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 9);
    idle(10, 9);
    chk("reset_count", rdata, 32'd5);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_regs", status | cause | epc | redirect, 32'd0);

    cyc(0, 9, 32'h8000_0100, 0, 0, 0, 0, 0, 13);
    chk("sys_flush", {31'd0, flush}, 32'd1);
    chk("sys_redirect", redirect, VEC);
    chk("sys_epc", epc, 32'h8000_0100);
    chk("sys_exccode", {27'd0, cause[6:2]}, 32'd8);
    chk("sys_exl", {31'd0, status[1]}, 32'd1);
    idle(1, 13);
    chk("sys_flush_drop", {31'd0, flush}, 32'd0);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 12);
    chk("eret1_redirect", redirect, 32'h8000_0100);
    idle(1, 12);

    cyc(0, 11, 32'h8000_0204, 1, 0, 0, 0, 0, 14);
    chk("ov_epc", epc, 32'h8000_0200);
    chk("ov_bd", {31'd0, cause[31]}, 32'd1);
    chk("ov_exccode", {27'd0, cause[6:2]}, 32'd12);
    idle(1, 14);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 12);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_redirect", redirect, 32'h8000_0200);
    chk("eret_exl", {31'd0, status[1]}, 32'd0);
    idle(1, 12);

    // Nested exception keeps EPC/BD
    cyc(0, 9, 32'h8000_0300, 1, 0, 0, 0, 0, 14);
    idle(1, 14);
    cyc(0, 10, 32'h8000_0400, 0, 0, 0, 0, 0, 14);
    chk("nest_epc", epc, 32'h8000_02FC);
    chk("nest_bd", {31'd0, cause[31]}, 32'd1);
    chk("nest_exccode", {27'd0, cause[6:2]}, 32'd10);
    chk("nest_flush", {31'd0, flush}, 32'd1);
    idle(1, 14);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 12);
    idle(1, 12);

    // mtc0 suppressed by a same-cycle exception; junk in FLUSH ignored
    cyc(0, 9, 32'h8000_0500, 0, 1, 12, 32'h0000_FF01, 0, 12);
    chk("sup_status", status, 32'h0000_0002);
    cyc(0, 9, 32'h8000_0600, 0, 1, 14, 32'h1234_5678, 0, 14);
    chk("flush_single", {31'd0, flush}, 32'd0);
    chk("flush_junk_epc", epc, 32'h8000_0500);
    cyc(0, 13, 0, 0, 0, 0, 0, 0, 12);
    idle(1, 12);

    // Timer
    mtc0(11, 32'd8);
    mtc0(9, 32'd0);
    idle(20, 9);
    chk("timer_ip7_set", {31'd0, cause[15]}, 32'd1);
    mtc0(11, 32'd20);
    idle(1, 13);
    chk("timer_ip7_clr", {31'd0, cause[15]}, 32'd0);
    mtc0(9, 32'hFFFF_FFFF);
    idle(4, 9);
    cyc(0, 0, 0, 0, 1, 13, 32'hFFFF_FFFF, 6'h2A, 13);
    idle(1, 13);

    // Reset in the flush cycle
    cyc(0, 12, 32'h8000_0700, 0, 0, 0, 0, 0, 14);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 14);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    idle(2, 9);

    for (int i = 0; i < 500; i++) begin
      et = ($urandom_range(99, 0) < 70) ? 32'd0 : 32'($urandom_range(15, 1));
      wa = addrs[$urandom_range(5, 0)];
      wd = (wa == 5'd11) ? m_count + 32'($urandom_range(12, 0)) : $urandom;
      iv = ($urandom_range(7, 0) == 0) ? 6'($urandom) : 6'd0;
      cyc(($urandom_range(99, 0) < 2) ? 1'b1 : 1'b0, et, $urandom,
          1'($urandom), ($urandom_range(99, 0) < 35) ? 1'b1 : 1'b0, wa, wd, iv,
          addrs[$urandom_range(5, 0)]);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
